// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default bundle widths,
// flush-mode encodings, control-bundle bit offsets and a valid-bit popcount.
package pipe_pkg;

   localparam int CTRL_W_DEF = 10;
   localparam int DATA_W_DEF = 47;

   localparam int FLUSH_BUBBLE = 0;
   localparam int FLUSH_ALL    = 1;

   localparam int REGWRITE_BIT = 9;
   localparam int MEMTOREG_BIT = 8;
   localparam int MEMWRITE_BIT = 7;
   localparam int ALUCTRL_MSB  = 6;
   localparam int ALUCTRL_LSB  = 4;
   localparam int ALUSRC_BIT   = 3;
   localparam int REGDST_BIT   = 2;
   localparam int BRANCH_BIT   = 1;
   localparam int SPARE_BIT    = 0;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline stage: clear beats load, load captures, otherwise hold.
// An invalid entry is captured with its control bundle forced to zero.
module pipe_stage_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W     = CTRL_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_valid,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [DATA_W-1:0] o_data,
   output logic              o_next_valid
);

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         if (CLEAR_DATA) r_data <= '0;
      end else if (i_load) begin
         r_valid <= i_valid;
         r_ctrl  <= i_valid ? i_ctrl : '0;
         r_data  <= i_data;
      end
   end

   // Lets the top register an occupancy that matches the stages after the edge.
   assign o_next_valid = i_clear ? 1'b0 : (i_load ? i_valid : r_valid);

   assign o_valid = r_valid;
   assign o_ctrl  = r_ctrl;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage control/data pipeline register with stall, flush and occupancy.
// Define PIPE_STAGE_PERF_EN to add the saturating BubbleCount output.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W     = CTRL_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DEPTH      = 1,
   parameter int FLUSH_MODE = FLUSH_BUBBLE,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              StallE,
   input  logic              FlushE,
   input  logic              ValidD,
   input  logic [CTRL_W-1:0] CtrlD,
   input  logic [DATA_W-1:0] DataD,
   output logic              ValidE,
   output logic [CTRL_W-1:0] CtrlE,
   output logic [DATA_W-1:0] DataE,
   output logic [3:0]        Occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,output logic [31:0]      BubbleCount
`endif
);

   // Index 0 is the input entry; index g+1 is the output of stage g+1.
   logic              w_valid [DEPTH+1];
   logic [CTRL_W-1:0] w_ctrl  [DEPTH+1];
   logic [DATA_W-1:0] w_data  [DEPTH+1];
   logic [DEPTH-1:0]  w_next_valid;
   logic [7:0]        w_next_valid8;
   logic              w_flush_rest;
   logic [3:0]        r_occupancy;

   assign w_valid[0]   = ValidD;
   assign w_ctrl[0]    = CtrlD;
   assign w_data[0]    = DataD;
   assign w_flush_rest = FlushE && (FLUSH_MODE == FLUSH_ALL);

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic w_clear;
      // Stage 1 always takes the flush; later stages only in flush-all mode.
      if (g == 0) begin : g_first
         assign w_clear = reset | FlushE;
      end else begin : g_rest
         assign w_clear = reset | w_flush_rest;
      end

      pipe_stage_slot #(
         .CTRL_W     (CTRL_W),
         .DATA_W     (DATA_W),
         .CLEAR_DATA (CLEAR_DATA)
      ) u_slot (
         .clk          (clk),
         .i_clear      (w_clear),
         .i_load       (~StallE),
         .i_valid      (w_valid[g]),
         .i_ctrl       (w_ctrl[g]),
         .i_data       (w_data[g]),
         .o_valid      (w_valid[g+1]),
         .o_ctrl       (w_ctrl[g+1]),
         .o_data       (w_data[g+1]),
         .o_next_valid (w_next_valid[g])
      );
   end

   always_comb begin
      w_next_valid8             = '0;
      w_next_valid8[DEPTH-1:0]  = w_next_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) r_occupancy <= '0;
      else       r_occupancy <= popcount8(w_next_valid8);
   end

   assign ValidE    = w_valid[DEPTH];
   assign CtrlE     = w_ctrl[DEPTH];
   assign DataE     = w_data[DEPTH];
   assign Occupancy = r_occupancy;

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] r_bubble_count;

   always_ff @(posedge clk) begin
      if (reset)                                      r_bubble_count <= '0;
      else if (!ValidE && (r_bubble_count != '1))     r_bubble_count <= r_bubble_count + 32'd1;
   end

   assign BubbleCount = r_bubble_count;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: table of directed steps on a DEPTH=3 bubble-flush
// instance, plus hand sequences on a DEPTH=3 flush-all, data-keeping instance.
module tb_pipe_stage_reg;

   localparam int CW = 10;
   localparam int DW = 47;

   localparam logic [CW-1:0] A_C = 10'h155;
   localparam logic [DW-1:0] A_D = 47'h1234;
   localparam logic [CW-1:0] B_C = 10'h0AA;
   localparam logic [DW-1:0] B_D = 47'h5678;
   localparam logic [CW-1:0] C_C = 10'h3FF;
   localparam logic [DW-1:0] C_D = 47'h7FFF_FFFF_FFFF;
   localparam logic [CW-1:0] D_C = 10'h2AA;
   localparam logic [DW-1:0] D_D = 47'h4000_0000_0001;
   localparam logic [CW-1:0] X_C = 10'h1FF;
   localparam logic [DW-1:0] X_D = 47'hDEAD;
   localparam logic [DW-1:0] N_D = 47'hABC;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          vld = 1'b0;
   logic [CW-1:0] ctrl = '0;
   logic [DW-1:0] data = '0;

   logic          a_valid, b_valid;
   logic [CW-1:0] a_ctrl, b_ctrl;
   logic [DW-1:0] a_data, b_data;
   logic [3:0]    a_occ, b_occ;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]   a_bub, b_bub;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3), .FLUSH_MODE(0), .CLEAR_DATA(1'b1)) dut_a (
      .clk(clk), .reset(reset), .StallE(stall), .FlushE(flush), .ValidD(vld), .CtrlD(ctrl), .DataD(data),
      .ValidE(a_valid), .CtrlE(a_ctrl), .DataE(a_data), .Occupancy(a_occ)
`ifdef PIPE_STAGE_PERF_EN
      , .BubbleCount(a_bub)
`endif
   );

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3), .FLUSH_MODE(1), .CLEAR_DATA(1'b0)) dut_b (
      .clk(clk), .reset(reset), .StallE(stall), .FlushE(flush), .ValidD(vld), .CtrlD(ctrl), .DataD(data),
      .ValidE(b_valid), .CtrlE(b_ctrl), .DataE(b_data), .Occupancy(b_occ)
`ifdef PIPE_STAGE_PERF_EN
      , .BubbleCount(b_bub)
`endif
   );

   typedef struct {
      logic          rst, stl, fls, v;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic          e_v;
      logic [CW-1:0] e_c;
      logic [DW-1:0] e_d;
      logic [3:0]    e_occ;
   } vec_t;

   localparam int NV = 38;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic rst, stl, fls, v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic e_v, input logic [CW-1:0] e_c, input logic [DW-1:0] e_d,
                               input logic [3:0] e_occ);
      vec_t t;
      t.rst = rst; t.stl = stl; t.fls = fls; t.v = v; t.c = c; t.d = d;
      t.e_v = e_v; t.e_c = e_c; t.e_d = e_d; t.e_occ = e_occ;
      return t;
   endfunction

   task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Apply one set of inputs across one rising edge; sample 1 time unit later.
   task automatic step(input logic rst, stl, fls, v, input logic [CW-1:0] c, input logic [DW-1:0] d);
      reset = rst; stall = stl; flush = fls; vld = v; ctrl = c; data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      // reset
      tbl[0]  = mk(1,0,0,0, '0,  '0,   0,'0,  '0,  0);
      tbl[1]  = mk(1,0,0,0, '0,  '0,   0,'0,  '0,  0);
      // latency: A,B,C back to back, occupancy 1,2,3,2,1,0
      tbl[2]  = mk(0,0,0,1, A_C, A_D,  0,'0,  '0,  1);
      tbl[3]  = mk(0,0,0,1, B_C, B_D,  0,'0,  '0,  2);
      tbl[4]  = mk(0,0,0,1, C_C, C_D,  1,A_C, A_D, 3);
      tbl[5]  = mk(0,0,0,0, '0,  '0,   1,B_C, B_D, 2);
      tbl[6]  = mk(0,0,0,0, '0,  '0,   1,C_C, C_D, 1);
      // invalid entry: ctrl forced to zero, data carried
      tbl[7]  = mk(0,0,0,0, C_C, N_D,  0,'0,  '0,  0);
      tbl[8]  = mk(0,0,0,0, '0,  '0,   0,'0,  '0,  0);
      tbl[9]  = mk(0,0,0,0, '0,  '0,   0,'0,  N_D, 0);
      tbl[10] = mk(0,0,0,0, '0,  '0,   0,'0,  '0,  0);
      // stall hold with D presented, then A,B,C,D
      tbl[11] = mk(0,0,0,1, A_C, A_D,  0,'0,  '0,  1);
      tbl[12] = mk(0,0,0,1, B_C, B_D,  0,'0,  '0,  2);
      tbl[13] = mk(0,0,0,1, C_C, C_D,  1,A_C, A_D, 3);
      tbl[14] = mk(0,1,0,1, D_C, D_D,  1,A_C, A_D, 3);
      tbl[15] = mk(0,1,0,1, D_C, D_D,  1,A_C, A_D, 3);
      tbl[16] = mk(0,1,0,1, D_C, D_D,  1,A_C, A_D, 3);
      tbl[17] = mk(0,1,0,1, D_C, D_D,  1,A_C, A_D, 3);
      tbl[18] = mk(0,0,0,1, D_C, D_D,  1,B_C, B_D, 3);
      tbl[19] = mk(0,0,0,0, '0,  '0,   1,C_C, C_D, 2);
      tbl[20] = mk(0,0,0,0, '0,  '0,   1,D_C, D_D, 1);
      tbl[21] = mk(0,0,0,0, '0,  '0,   0,'0,  '0,  0);
      // flush bubble: X discarded, bubble in its slot
      tbl[22] = mk(0,0,0,1, A_C, A_D,  0,'0,  '0,  1);
      tbl[23] = mk(0,0,0,1, B_C, B_D,  0,'0,  '0,  2);
      tbl[24] = mk(0,0,1,1, X_C, X_D,  1,A_C, A_D, 2);
      tbl[25] = mk(0,0,0,0, '0,  '0,   1,B_C, B_D, 1);
      tbl[26] = mk(0,0,0,0, '0,  '0,   0,'0,  '0,  0);
      tbl[27] = mk(0,0,0,0, '0,  '0,   0,'0,  '0,  0);
      // flush bubble while stalled: stage 1 cleared, later stages hold
      tbl[28] = mk(0,0,0,1, A_C, A_D,  0,'0,  '0,  1);
      tbl[29] = mk(0,0,0,1, B_C, B_D,  0,'0,  '0,  2);
      tbl[30] = mk(0,0,0,1, C_C, C_D,  1,A_C, A_D, 3);
      tbl[31] = mk(0,1,1,1, X_C, X_D,  1,A_C, A_D, 2);
      tbl[32] = mk(0,0,0,0, '0,  '0,   1,B_C, B_D, 1);
      tbl[33] = mk(0,0,0,0, '0,  '0,   0,'0,  '0,  0);
      // reset wins over everything and wipes entries in flight
      tbl[34] = mk(0,0,0,1, A_C, A_D,  0,'0,  '0,  1);
      tbl[35] = mk(1,1,1,1, B_C, B_D,  0,'0,  '0,  0);
      tbl[36] = mk(0,0,0,0, '0,  '0,   0,'0,  '0,  0);
      tbl[37] = mk(0,0,0,0, '0,  '0,   0,'0,  '0,  0);

      #1;
      for (int i = 0; i < NV; i++) begin
         step(tbl[i].rst, tbl[i].stl, tbl[i].fls, tbl[i].v, tbl[i].c, tbl[i].d);
         check("ValidE",    i, 64'(a_valid), 64'(tbl[i].e_v));
         check("CtrlE",     i, 64'(a_ctrl),  64'(tbl[i].e_c));
         check("DataE",     i, 64'(a_data),  64'(tbl[i].e_d));
         check("Occupancy", i, 64'(a_occ),   64'(tbl[i].e_occ));
      end

      // flush-all with simultaneous stall, data kept (dut_b)
      step(1,0,0,0,'0,'0);
      step(1,0,0,0,'0,'0);
      step(0,0,0,1,A_C,A_D);
      step(0,0,0,1,B_C,B_D);
      step(0,0,0,1,C_C,C_D);
      check("b_full_occ",  100, 64'(b_occ),   64'd3);
      check("b_full_data", 100, 64'(b_data),  64'(A_D));
      step(0,1,1,1,X_C,X_D);
      check("b_flush_occ",   101, 64'(b_occ),   64'd0);
      check("b_flush_valid", 101, 64'(b_valid), 64'd0);
      check("b_flush_ctrl",  101, 64'(b_ctrl),  64'd0);
      check("b_flush_data",  101, 64'(b_data),  64'(A_D));
      check("a_flush_occ",   101, 64'(a_occ),   64'd2);
      check("a_flush_ctrl",  101, 64'(a_ctrl),  64'(A_C));
      idle();
      check("b_shift_data",  102, 64'(b_data),  64'(B_D));
      check("b_shift_valid", 102, 64'(b_valid), 64'd0);
      step(1,0,0,1,C_C,C_D);
      check("b_reset_data",  103, 64'(b_data),  64'(B_D));
      check("b_reset_occ",   103, 64'(b_occ),   64'd0);
      check("a_reset_data",  103, 64'(a_data),  64'd0);

`ifdef PIPE_STAGE_PERF_EN
      step(1,0,0,0,'0,'0);
      check("bubble_reset", 200, 64'(a_bub), 64'd0);
      for (int i = 0; i < 5; i++) idle();
      check("bubble_5", 201, 64'(a_bub), 64'd5);
      dut_a.r_bubble_count = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) idle();
      check("bubble_sat", 202, 64'(a_bub), 64'hFFFF_FFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
